// File: rtl/mmio_axi_lite_master.sv
// AXI4-Lite initiator: one outstanding MMIO access from a valid/ready command port.
// Optional address window check enabled by defining MMIO_AXI_ADDR_CHECK_EN.
module mmio_axi_lite_master #(
    parameter logic [31:0] ADDR_BASE = 32'h4600_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000
) (
    input  logic        aclk,
    input  logic        arst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic [31:0] M_AXI_awaddr,
    output logic [2:0]  M_AXI_awprot,
    output logic        M_AXI_awvalid,
    input  logic        M_AXI_awready,
    output logic [31:0] M_AXI_wdata,
    output logic [3:0]  M_AXI_wstrb,
    output logic        M_AXI_wvalid,
    input  logic        M_AXI_wready,
    input  logic [1:0]  M_AXI_bresp,
    input  logic        M_AXI_bvalid,
    output logic        M_AXI_bready,
    output logic [31:0] M_AXI_araddr,
    output logic [2:0]  M_AXI_arprot,
    output logic        M_AXI_arvalid,
    input  logic        M_AXI_arready,
    input  logic [31:0] M_AXI_rdata,
    input  logic [1:0]  M_AXI_rresp,
    input  logic        M_AXI_rvalid,
    output logic        M_AXI_rready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WR_B = 3'd2,
        RD_A = 3'd3,
        RD_R = 3'd4,
        RSP  = 3'd5,
        DEC  = 3'd6
    } state_t;

`ifdef MMIO_AXI_ADDR_CHECK_EN
    localparam logic ADDR_CHECK = 1'b1;
`else
    localparam logic ADDR_CHECK = 1'b0;
`endif

    state_t      state_r;
    logic        cmd_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic [1:0]  rsp_resp_r;
    logic [31:0] awaddr_r;
    logic        awvalid_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        wvalid_r;
    logic        bready_r;
    logic [31:0] araddr_r;
    logic        arvalid_r;
    logic        rready_r;

    logic        addr_ok_s;
    logic        decerr_s;
    logic        aw_done_s;
    logic        w_done_s;

    // Window match and per-channel completion; constant-folds away when the check is disabled
    always_comb begin
        addr_ok_s = ((cmd_addr & ADDR_MASK) == ADDR_BASE);
        decerr_s  = ADDR_CHECK & ~addr_ok_s;
        aw_done_s = ~awvalid_r | M_AXI_awready;
        w_done_s  = ~wvalid_r | M_AXI_wready;
    end

    // Transaction FSM; every interface output is a register updated here
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_resp_r  <= 2'b00;
            awaddr_r    <= 32'h0000_0000;
            awvalid_r   <= 1'b0;
            wdata_r     <= 32'h0000_0000;
            wstrb_r     <= 4'h0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            araddr_r    <= 32'h0000_0000;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // cmd_ready lags reset release by one cycle so it is always state-derived
                    if (!cmd_ready_r) begin
                        cmd_ready_r <= 1'b1;
                    end else if (cmd_valid) begin
                        cmd_ready_r <= 1'b0;
                        if (decerr_s) begin
                            state_r <= DEC;
                        end else if (cmd_write) begin
                            awaddr_r  <= {cmd_addr[31:2], 2'b00};
                            wdata_r   <= cmd_wdata;
                            wstrb_r   <= cmd_wstrb;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            state_r   <= WR;
                        end else begin
                            araddr_r  <= {cmd_addr[31:2], 2'b00};
                            arvalid_r <= 1'b1;
                            state_r   <= RD_A;
                        end
                    end
                end
                WR: begin
                    if (M_AXI_awready) begin
                        awvalid_r <= 1'b0;
                    end
                    if (M_AXI_wready) begin
                        wvalid_r <= 1'b0;
                    end
                    if (aw_done_s && w_done_s) begin
                        bready_r <= 1'b1;
                        state_r  <= WR_B;
                    end
                end
                WR_B: begin
                    if (M_AXI_bvalid) begin
                        bready_r    <= 1'b0;
                        rsp_resp_r  <= M_AXI_bresp;
                        rsp_rdata_r <= 32'h0000_0000;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RSP;
                    end
                end
                RD_A: begin
                    if (M_AXI_arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= RD_R;
                    end
                end
                RD_R: begin
                    if (M_AXI_rvalid) begin
                        rready_r    <= 1'b0;
                        rsp_rdata_r <= M_AXI_rdata;
                        rsp_resp_r  <= M_AXI_rresp;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RSP;
                    end
                end
                DEC: begin
                    rsp_resp_r  <= 2'b11;
                    rsp_rdata_r <= 32'h0000_0000;
                    rsp_valid_r <= 1'b1;
                    state_r     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    cmd_ready_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign rsp_resp      = rsp_resp_r;
    assign M_AXI_awaddr  = awaddr_r;
    assign M_AXI_awprot  = 3'b000;
    assign M_AXI_awvalid = awvalid_r;
    assign M_AXI_wdata   = wdata_r;
    assign M_AXI_wstrb   = wstrb_r;
    assign M_AXI_wvalid  = wvalid_r;
    assign M_AXI_bready  = bready_r;
    assign M_AXI_araddr  = araddr_r;
    assign M_AXI_arprot  = 3'b000;
    assign M_AXI_arvalid = arvalid_r;
    assign M_AXI_rready  = rready_r;

endmodule

// File: doc/mmio_axi_lite_master.md
Name: mmio_axi_lite_master

Overview:
- AXI4-Lite initiator that issues MMIO accesses into the MMIO subsystem's AXI-Lite slave port (e.g. GPIO window 32'h4600_01XX).
- Converts a simple valid/ready command/response interface from a local requester (test sequencer, boot ROM walker, debug bridge) into protocol-compliant AW/W/B and AR/R transactions.
- Single outstanding transaction; all AXI outputs are registered.

Parameters:
- ADDR_BASE, 32'h4600_0000, base of the legal MMIO window. Used only with the optional feature.
- ADDR_MASK, 32'hFFFF_0000, bits compared against ADDR_BASE. Used only with the optional feature.

Ports:
- aclk  in  1  clock
- arst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data (0 for writes)
- rsp_resp  out  2  AXI response code (OKAY=00, SLVERR=10, DECERR=11)
- M_AXI_awaddr  out  32;  M_AXI_awprot  out  3;  M_AXI_awvalid  out  1;  M_AXI_awready  in  1
- M_AXI_wdata  out  32;  M_AXI_wstrb  out  4;  M_AXI_wvalid  out  1;  M_AXI_wready  in  1
- M_AXI_bresp  in  2;  M_AXI_bvalid  in  1;  M_AXI_bready  out  1
- M_AXI_araddr  out  32;  M_AXI_arprot  out  3;  M_AXI_arvalid  out  1;  M_AXI_arready  in  1
- M_AXI_rdata  in  32;  M_AXI_rresp  in  2;  M_AXI_rvalid  in  1;  M_AXI_rready  out  1

Behaviour:
- Reset (arst_n low at a posedge): state=IDLE. All valid/ready outputs=0, rsp_rdata=0, rsp_resp=0, awaddr/araddr/wdata=0, wstrb=0. Any in-flight transaction is abandoned and produces no response.
- awprot and arprot are constant 3'b000.
- Address bits [1:0] are forced to 0 on awaddr/araddr.
- cmd_ready = (state==IDLE). It is registered-derived, so it is never high in the same cycle as rsp_valid.
- IDLE: on cmd_valid, latch addr/wdata/wstrb.
  - cmd_write=1 -> WR. awvalid=1 and wvalid=1 from the next cycle.
  - cmd_write=0 -> RD_A. arvalid=1 from the next cycle.
- WR: awvalid and wvalid are dropped independently in the cycle after their own handshake. Both may complete in the same cycle, in either order. aw/w payloads stay stable while valid. When both are done -> WR_B.
- WR_B: bready=1. On bvalid, capture bresp into rsp_resp, set rsp_rdata=0, go to RSP, and drop bready the next cycle.
- RD_A: arvalid held with araddr stable until arready. Then arvalid=0 -> RD_R.
- RD_R: rready=1. On rvalid, capture rdata/rresp, go to RSP, and drop rready.
- RSP: rsp_valid=1 with rsp_rdata/rsp_resp stable until rsp_ready. Then -> IDLE.
- Latency with all slave readies high and zero-wait responses:
  - Command accept cycle N: aw/w/ar valid at N+1.
  - B/R handshake at N+2.
  - rsp_valid at N+3.
  - The next command can be accepted in the cycle after rsp_ready.
- No valid is ever deasserted before its handshake. No new AW/W/AR is issued until the prior B/R has completed.
- An unexpected bvalid/rvalid outside WR_B/RD_R is ignored (ready stays 0).

Optional Feature:
- Macro MMIO_AXI_ADDR_CHECK_EN.
- Defined: in IDLE, a command with (cmd_addr & ADDR_MASK) != ADDR_BASE is accepted but issues no AXI traffic. Next cycle -> RSP with rsp_resp=2'b11 (DECERR), rsp_rdata=0.
- Undefined: every command is forwarded to AXI unchanged. ADDR_BASE and ADDR_MASK are unused.

Test Plan:
- Write 32'h4600_0104, data 32'hDEAD_BEEF, wstrb 4'hF, slave all-ready, bresp=00:
  - awvalid and wvalid high for exactly 1 cycle at N+1.
  - rsp_valid at N+3 with rsp_resp=00, rsp_rdata=0.
- Write with awready delayed 3 cycles and wready immediate:
  - wvalid drops after 1 cycle; awvalid held 4 cycles with awaddr stable; no bready before both handshakes.
- Read 32'h4600_0108, rvalid after 5-cycle delay, rdata 32'h0000_00A5, rresp=00:
  - rsp_rdata=32'h0000_00A5 and rsp_resp=00; arvalid high exactly until arready.
- rsp_ready held low 4 cycles, then a read returning rresp=10:
  - rsp_valid/rsp_rdata/rsp_resp stable for all 4 cycles; cmd_ready=0 throughout; rsp_resp=10.
- Reset while in WR_B (bvalid not yet seen):
  - All M_AXI valids/readies and rsp_valid=0 the cycle after reset; cmd_ready=1 after reset release.
- With MMIO_AXI_ADDR_CHECK_EN, read 32'h5000_0000:
  - No arvalid asserted; rsp_valid with rsp_resp=11, rsp_rdata=0, two cycles after acceptance.
